vlb_regmem_v2: RTL and testbench

Second-generation VLB memory controller with embedded register file: a 2**AWIDTH x DWIDTH memory plus DATA, CTRL, VOLATILE, STATUS and INTR registers decoded at fixed addresses. A valid/ready request port with byte enables and a fixed-latency response port replace the single-cycle wr_rd strobe. Adds hardware memory initialisation, soft clear, W1C interrupts and error responses. Sits behind the VLB bus agent as the register-verification DUT.

---
 rtl/vlb2_regs_pkg.sv | 45 ++++
 rtl/vlb2_rsp_pipe.sv | 51 +++++
 rtl/vlb_regmem_v2.sv | 218 +++++++++++++++++++++
 tb/tb_vlb_regmem_v2.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlb2_regs_pkg.sv
// vlb2_regs_pkg: shared definitions for the VLB memory controller with
// embedded register file.
//   - register word addresses (DATA, CTRL, VOLATILE, STATUS, INTR)
//   - CTRL / INTR / STATUS bit-index constants
//   - controller state enum
//   - response record carried through the fixed-latency response pipe
package vlb2_regs_pkg;

  // Register word addresses; every other address maps onto memory.
  localparam int unsigned ADDR_DATA     = 0;
  localparam int unsigned ADDR_CTRL     = 1;
  localparam int unsigned ADDR_VOLATILE = 2;
  localparam int unsigned ADDR_STATUS   = 3;
  localparam int unsigned ADDR_INTR     = 4;

  // CTRL fields
  localparam int unsigned CTRL_SOFT_CLR = 0;
  localparam int unsigned CTRL_IEN_LO   = 1;
  localparam int unsigned CTRL_IEN_HI   = 2;

  // INTR fields (W1C)
  localparam int unsigned INTR_WRAP     = 0;
  localparam int unsigned INTR_ILLEGAL  = 1;

  // STATUS fields
  localparam int unsigned STATUS_BUSY      = 0;
  localparam int unsigned STATUS_ERRCNT_LO = 8;
  localparam int unsigned STATUS_ERRCNT_HI = 15;

  // Widest supported data path; the response record is sized for it and
  // the unused upper bits are constant zero for narrower instances.
  localparam int unsigned MAX_DWIDTH = 64;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [MAX_DWIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/vlb2_rsp_pipe.sv
// vlb2_rsp_pipe: DEPTH-stage valid/data shift pipeline with async reset.
// Stage 0 loads on the edge that accepts a request, so the output is valid
// in the DEPTH-th cycle counted from that acceptance edge.
//   clk, rst_n  clock, asynchronous active-low reset (flushes every stage)
//   in_valid    response present this cycle
//   in_data     response payload (W bits)
//   out_valid   one-cycle response pulse at the end of the pipe
//   out_data    payload paired with out_valid
module vlb2_rsp_pipe #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here by construction, elsewhere via defaults first) so no latch forms.
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/vlb_regmem_v2.sv
// vlb_regmem_v2: VLB memory controller with embedded register file.
// A 2**AWIDTH x DWIDTH memory plus DATA/CTRL/VOLATILE/STATUS/INTR registers
// behind a valid/ready request port and a fixed-latency response port.
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    request present; accepted when req_ready is also high
//   req_ready    high only in READY (not while memory is being zeroed)
//   req_wr       1 = write, 0 = read
//   req_addr     word address
//   req_wdata    write data
//   req_be       per-byte write enables
//   rsp_valid    one-cycle pulse RD_LAT cycles after acceptance (the cycle
//                ending at acceptance edge + RD_LAT); no backpressure
//   rsp_rdata    read data, 0 for writes
//   rsp_err      write to a read-only register
//   irq          registered OR of enabled INTR bits
module vlb_regmem_v2 #(
  parameter int unsigned       DWIDTH      = 32,
  parameter int unsigned       AWIDTH      = 8,
  parameter int unsigned       RD_LAT      = 1,
  parameter logic [DWIDTH-1:0] VOL_RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                irq
);

  import vlb2_regs_pkg::*;

  localparam int unsigned NBYTES = DWIDTH / 8;
  localparam int unsigned DEPTH  = 1 << AWIDTH;

  // Registered state
  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [AWIDTH-1:0]   idx_q, idx_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [DWIDTH-1:0]   ctrl_q, ctrl_d;
  logic [DWIDTH-1:0]   vol_q, vol_d;
  logic [1:0]          intr_q, intr_d;
  logic [7:0]          errcnt_q, errcnt_d;
  logic                irq_q, irq_d;

  // Memory and its single write port
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [DWIDTH-1:0]   mem_wdata;

  // Request decode
  logic                accept;
  logic [DWIDTH-1:0]   be_mask;
  logic [DWIDTH-1:0]   mem_rdata;
  logic [DWIDTH-1:0]   status_w;
  logic [DWIDTH-1:0]   ctrl_merged;
  logic                hit_data, hit_ctrl, hit_vol, hit_status, hit_intr;
  logic [1:0]          intr_set, intr_clr;
  logic [DWIDTH-1:0]   rd_data;
  logic                rd_err;

  // Response pipe
  rsp_t                rsp_in, rsp_out;
  logic                unused_rsp_bits;

  assign accept     = req_valid & ready_q;
  assign mem_rdata  = mem[req_addr];
  assign hit_data   = (req_addr == AWIDTH'(ADDR_DATA));
  assign hit_ctrl   = (req_addr == AWIDTH'(ADDR_CTRL));
  assign hit_vol    = (req_addr == AWIDTH'(ADDR_VOLATILE));
  assign hit_status = (req_addr == AWIDTH'(ADDR_STATUS));
  assign hit_intr   = (req_addr == AWIDTH'(ADDR_INTR));

  always_comb begin
    for (int b = 0; b < int'(NBYTES); b++) be_mask[b*8 +: 8] = {8{req_be[b]}};
  end

  always_comb begin
    status_w = '0;
    status_w[STATUS_BUSY] = (state_q != ST_READY);
    status_w[STATUS_ERRCNT_HI:STATUS_ERRCNT_LO] = errcnt_q;
  end

  assign ctrl_merged = (ctrl_q & ~be_mask) | (req_wdata & be_mask);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    vol_d     = vol_q;
    errcnt_d  = errcnt_q;
    intr_set  = '0;
    intr_clr  = '0;
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wdata = '0;
    rd_data   = '0;
    rd_err    = 1'b0;

    // VOLATILE counts every accepted request, whatever it targets.
    if (accept) begin
      vol_d = vol_q + DWIDTH'(1);
      if (vol_q == '1) intr_set[INTR_WRAP] = 1'b1;
    end

    unique case (state_q)
      ST_INIT, ST_CLEAR: begin
        // Zero one word per cycle; leave on the edge that clears the last.
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        idx_d     = idx_q + AWIDTH'(1);
        if (idx_q == '1) state_d = ST_READY;
      end
      ST_READY: begin
        if (accept && req_wr) begin
          if (hit_data) begin
            data_d = (data_q & ~be_mask) | (req_wdata & be_mask);
          end else if (hit_ctrl) begin
            // SOFT_CLR never stores; it only launches the clear sequence.
            ctrl_d = ctrl_merged;
            ctrl_d[CTRL_SOFT_CLR] = 1'b0;
            if (ctrl_merged[CTRL_SOFT_CLR]) begin
              state_d = ST_CLEAR;
              idx_d   = '0;
            end
          end else if (hit_vol || hit_status) begin
            rd_err = 1'b1;
            intr_set[INTR_ILLEGAL] = 1'b1;
            if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
          end else if (hit_intr) begin
            if (req_be[0]) intr_clr = req_wdata[1:0];
          end else begin
            mem_we    = 1'b1;
            mem_wdata = (mem_rdata & ~be_mask) | (req_wdata & be_mask);
          end
        end else if (accept) begin
          if (hit_data)        rd_data = data_q;
          else if (hit_ctrl)   rd_data = ctrl_q;
          else if (hit_vol)    rd_data = vol_q;
          else if (hit_status) rd_data = status_w;
          else if (hit_intr)   rd_data = {{(DWIDTH-2){1'b0}}, intr_q};
          else                 rd_data = mem_rdata;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A set and a clear of the same bit in one cycle leave the bit set.
    intr_d  = (intr_q & ~intr_clr) | intr_set;
    irq_d   = |(intr_d & ctrl_d[CTRL_IEN_HI:CTRL_IEN_LO]);
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      ready_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      vol_q    <= VOL_RST_VAL;
      intr_q   <= '0;
      errcnt_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      vol_q    <= vol_d;
      intr_q   <= intr_d;
      errcnt_q <= errcnt_d;
      irq_q    <= irq_d;
    end
  end

  // NOTE: the memory array has no reset; INIT zeroes it word by word after
  // every reset, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.rdata = MAX_DWIDTH'(rd_data);
    rsp_in.err   = rd_err;
  end

  vlb2_rsp_pipe #(
    .W     ($bits(rsp_t)),
    .DEPTH (RD_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (rsp_in),
    .out_valid (rsp_valid),
    .out_data  (rsp_out)
  );

  // Upper payload bits are constant zero when DWIDTH < MAX_DWIDTH.
  assign unused_rsp_bits = ^rsp_out.rdata;

  assign rsp_rdata = rsp_out.rdata[DWIDTH-1:0];
  assign rsp_err   = rsp_out.err;
  assign req_ready = ready_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_vlb_regmem_v2.sv
// Self-checking bench for vlb_regmem_v2 (DWIDTH=32, AWIDTH=5, RD_LAT=4,
// VOL_RST_VAL=FFFFFFFE). A behavioural model tracks registers, memory and
// the expected response stream; a compare process checks every cycle, and
// directed sequences pin literal values.
module tb_vlb_regmem_v2;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] VOL_INIT = 32'hFFFF_FFFE;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          irq;

  int checks = 0;
  int errors = 0;

  vlb_regmem_v2 #(
    .DWIDTH      (DW),
    .AWIDTH      (AW),
    .RD_LAT      (LAT),
    .VOL_RST_VAL (VOL_INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint      due;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] data_m   = '0;
  logic [31:0] ctrl_m   = '0;
  logic [31:0] vol_m    = VOL_INIT;
  logic [1:0]  intr_m   = '0;
  int          errcnt_m = 0;
  int          busy_left = DEPTH;
  longint      cyc = 0;
  exp_t        exp_q[$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic void m_reset();
    data_m    = '0;
    ctrl_m    = '0;
    vol_m     = VOL_INIT;
    intr_m    = '0;
    busy_left = DEPTH;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    exp_q.delete();
  endfunction

  // The error count survives everything but reset, so it is cleared here only.
  always @(posedge clk or negedge rst_n) begin : model
    bit          acc;
    logic [31:0] rd;
    logic        er;
    logic [1:0]  set;
    logic [1:0]  clr;
    logic [31:0] tmp;
    int          a;
    exp_t        e;
    if (!rst_n) begin
      m_reset();
      errcnt_m = 0;
    end else begin
      cyc++;
      acc = req_valid && (busy_left == 0);
      if (busy_left > 0) busy_left--;
      if (acc) begin
        rd  = '0;
        er  = 1'b0;
        set = '0;
        clr = '0;
        a   = int'(req_addr);
        if (vol_m == 32'hFFFF_FFFF) set[0] = 1'b1;
        if (!req_wr) begin
          case (a)
            0:       rd = data_m;
            1:       rd = ctrl_m;
            2:       rd = vol_m;
            3:       rd = 32'(errcnt_m) << 8;
            4:       rd = {30'b0, intr_m};
            default: rd = mem_m[a];
          endcase
        end else begin
          case (a)
            0: data_m = merge(data_m, req_wdata, req_be);
            1: begin
              tmp = merge(ctrl_m, req_wdata, req_be);
              if (tmp[0]) begin
                busy_left = DEPTH;
                for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
              end
              ctrl_m = tmp & 32'hFFFF_FFFE;
            end
            2, 3: begin
              er     = 1'b1;
              set[1] = 1'b1;
              if (errcnt_m < 255) errcnt_m++;
            end
            4: if (req_be[0]) clr = req_wdata[1:0];
            default: mem_m[a] = merge(mem_m[a], req_wdata, req_be);
          endcase
        end
        vol_m  = vol_m + 32'd1;
        intr_m = (intr_m & ~clr) | set;
        e.due  = cyc + longint'(LAT) - 1;
        e.rd   = rd;
        e.err  = er;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_irq", irq, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
    end else begin
      check("req_ready", req_ready, busy_left == 0);
      check("irq", irq, |(intr_m & ctrl_m[2:1]));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_q[0].rd);
        check("rsp_err", rsp_err, exp_q[0].err);
        void'(exp_q.pop_front());
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input string name, input bit wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_accept"}, req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check({name, "_rsp_seen"}, rsp_valid, 1);
    check({name, "_latency"}, n, LAT);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    do_req(name, 1'b0, a, '0, '0, rd, er);
    check(name, rd, exp);
    check({name, "_err"}, er, 0);
  endtask

  task automatic wr_chk(input string name, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    do_req(name, 1'b1, a, wd, be, rd, er);
    check({name, "_rdata"}, rd, 0);
    check({name, "_err"}, er, exp_err);
  endtask

  // Counts consecutive cycles with req_ready low, starting mid-cycle.
  task automatic measure_busy(output int n, output bit saw_rsp, output logic rsp_e);
    n       = 0;
    saw_rsp = 1'b0;
    rsp_e   = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        saw_rsp = 1'b1;
        rsp_e   = rsp_err;
      end
      if (req_ready || n >= 200) break;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int          n;
    int          pulses;
    bit          saw;
    logic        se;
    logic [31:0] wd;
    logic [AW-1:0] ad;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    measure_busy(n, saw, se);
    check("init_cycles", n, DEPTH);

    // Counter near wrap: pre-increment read values, wrap interrupt.
    rd_chk("vol_rd0", 5'd2, 32'hFFFF_FFFE);
    rd_chk("vol_rd1", 5'd2, 32'hFFFF_FFFF);
    rd_chk("vol_rd2", 5'd2, 32'h0000_0000);
    rd_chk("intr_wrap", 5'd4, 32'h1);
    wr_chk("ctrl_ien", 5'd1, 32'h2, 4'hF, 1'b0);
    check("irq_on", irq, 1);
    wr_chk("intr_w1c", 5'd4, 32'h1, 4'hF, 1'b0);
    check("irq_off", irq, 0);
    rd_chk("intr_clear", 5'd4, 32'h0);

    // Byte enables on memory.
    rd_chk("mem_init", 5'h10, 32'h0);
    wr_chk("mem_be_wr", 5'h10, 32'hDEAD_BEEF, 4'b0101, 1'b0);
    rd_chk("mem_be_rd", 5'h10, 32'h00AD_00EF);

    // Illegal writes.
    wr_chk("status_wr", 5'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("irq_ill_masked", irq, 0);
    rd_chk("intr_ill", 5'd4, 32'h2);
    rd_chk("status_cnt1", 5'd3, 32'h0000_0100);
    wr_chk("vol_wr", 5'd2, 32'h1234, 4'hF, 1'b1);
    rd_chk("status_cnt2", 5'd3, 32'h0000_0200);
    wr_chk("intr_w1c2", 5'd4, 32'h2, 4'h1, 1'b0);
    rd_chk("intr_clear2", 5'd4, 32'h0);

    // Fill DATA and memory, then soft clear.
    wr_chk("data_wr", 5'd0, 32'h1234_5678, 4'hF, 1'b0);
    for (int i = 5; i < int'(DEPTH); i++)
      wr_chk("fill", AW'(i), 32'h0101_0101 * 32'(i), 4'hF, 1'b0);
    rd_chk("fill_rd", 5'h1F, 32'h1F1F_1F1F);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("softclr_accept", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 5'd1;
    req_wdata = 32'h1;
    req_be    = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    measure_busy(n, saw, se);
    check("softclr_busy", n, DEPTH);
    check("softclr_rsp_seen", saw, 1);
    check("softclr_rsp_err", se, 0);
    rd_chk("ctrl_after_clr", 5'd1, 32'h0);
    rd_chk("data_kept", 5'd0, 32'h1234_5678);
    rd_chk("mem_cleared10", 5'h10, 32'h0);
    rd_chk("mem_cleared1f", 5'h1F, 32'h0);

    // Randomised traffic, back-to-back, checked by the model.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      req_valid = ($urandom % 10) < 7;
      req_wr    = 1'($urandom % 2);
      if ($urandom % 2 == 0) ad = AW'($urandom_range(0, 4));
      else                   ad = AW'($urandom_range(5, DEPTH - 1));
      req_addr  = ad;
      wd        = $urandom;
      if (ad == 5'd1 && ($urandom % 8) != 0) wd[0] = 1'b0;
      req_wdata = wd;
      req_be    = 4'($urandom % 16);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Reset with three reads in flight.
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("flush_accept", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 5'd2;
    @(posedge clk);
    #1 req_addr = 5'h10;
    @(posedge clk);
    #1 req_addr = 5'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    pulses    = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("flush_pulses", pulses, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    measure_busy(n, saw, se);
    check("reinit_cycles", n, DEPTH);
    check("reinit_no_rsp", saw, 0);
    rd_chk("vol_after_rst", 5'd2, 32'hFFFF_FFFE);
    rd_chk("data_after_rst", 5'd0, 32'h0);

    repeat (LAT + 2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
